// File: rtl/button_debounce.sv
// Push-button front end: two-flop synchroniser, consecutive-sample debounce,
// and a small FSM that publishes a clean level, press/release/long-press
// pulses and a wrapping press counter.
//
// Ports:
//   clk           system clock, all logic on posedge
//   rst_n         asynchronous active-low reset
//   btn_in        raw asynchronous button pin
//   pressed       debounced level, 1 while the button is accepted as held
//   press_pulse   one-cycle pulse on an accepted press
//   release_pulse one-cycle pulse on an accepted release
//   long_pulse    one-cycle pulse when a press has been held long enough
//   press_count   accepted presses, wraps 255 -> 0
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES   = 10,
    parameter int unsigned LONG_PRESS_CYCLES = 50,
    parameter bit          BTN_ACTIVE_LOW    = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_in,
    output logic       pressed,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_PRESSED  = 2'd1,
        ST_LONG     = 2'd2
    } state_t;

    localparam logic [31:0] DB_LAST   = DEBOUNCE_CYCLES - 1;
    localparam logic [31:0] LONG_LAST = LONG_PRESS_CYCLES - 1;

    logic        sync1;
    logic        sync2;
    logic        btn_s;

    state_t      state;
    state_t      state_d;
    logic [31:0] db_cnt;
    logic [31:0] db_cnt_d;
    logic [31:0] hold_cnt;
    logic [31:0] hold_cnt_d;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic        press_q;
    logic        press_d;
    logic        rel_q;
    logic        rel_d;
    logic        long_q;
    logic        long_d;

    logic        level;
    logic        diff;
    logic        acc;
    logic        long_hit;

    // Sync flops park at the pin's released level so reset never looks
    // like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= BTN_ACTIVE_LOW;
            sync2 <= BTN_ACTIVE_LOW;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    // Normalised so that 1 always means "pressed".
    assign btn_s = sync2 ^ BTN_ACTIVE_LOW;

    // State register plus counters and registered pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RELEASED;
            db_cnt   <= '0;
            hold_cnt <= '0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
            long_q   <= 1'b0;
        end else begin
            state    <= state_d;
            db_cnt   <= db_cnt_d;
            hold_cnt <= hold_cnt_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
            rel_q    <= rel_d;
            long_q   <= long_d;
        end
    end

    // Next-state logic. A release acceptance outranks the long-press
    // threshold when both land in the same cycle.
    always_comb begin
        level    = (state != ST_RELEASED);
        diff     = (btn_s != level);
        acc      = diff && (db_cnt == DB_LAST);
        long_hit = (state == ST_PRESSED) && (hold_cnt == LONG_LAST);

        state_d    = state;
        db_cnt_d   = '0;
        hold_cnt_d = hold_cnt;
        cnt_d      = cnt_q;
        press_d    = 1'b0;
        rel_d      = 1'b0;
        long_d     = 1'b0;

        // Any sample matching the accepted level restarts the count.
        if (diff && !acc) begin
            db_cnt_d = db_cnt + 32'd1;
        end

        // Hold time keeps running through release bounce.
        if (state == ST_PRESSED) begin
            hold_cnt_d = hold_cnt + 32'd1;
        end

        unique case (1'b1)
            acc && !level: begin
                state_d    = ST_PRESSED;
                hold_cnt_d = '0;
                cnt_d      = cnt_q + 8'd1;
                press_d    = 1'b1;
            end
            acc && level: begin
                state_d    = ST_RELEASED;
                hold_cnt_d = '0;
                rel_d      = 1'b1;
            end
            long_hit && !acc: begin
                state_d    = ST_LONG;
                hold_cnt_d = hold_cnt;
                long_d     = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Output decode.
    always_comb begin
        pressed       = (state != ST_RELEASED);
        press_pulse   = press_q;
        release_pulse = rel_q;
        long_pulse    = long_q;
        press_count   = cnt_q;
    end

endmodule
